// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM read-return path.
package psram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } rd_pack_state_e;

   localparam int unsigned PSRAM_BEAT_BYTES = 8;

endpackage

// File: rtl/psram_rd_fifo.sv
// Synchronous beat FIFO; the caller only pushes when there is room or a pop
// happens in the same cycle, and only pops when the FIFO is not empty.
module psram_rd_fifo #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          push_i,
   input  logic [DATA_WIDTH-1:0]         data_i,
   input  logic                          pop_i,
   output logic [DATA_WIDTH-1:0]         data_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   cnt_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/psram_rd_packer.sv
// Packs PSRAM read bytes little-endian into beats and returns them over rvalid/rready.
// Optional PSRAM_RD_OFFSET_EN adds off_i: leading bytes consumed but not packed.
module psram_rd_packer
   import psram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = PSRAM_BEAT_BYTES * 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic                  byte_vld_i,
   input  logic [7:0]            byte_i,
   output logic                  byte_rdy_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rlast_o,
   input  logic                  rready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ovf_o
`ifdef PSRAM_RD_OFFSET_EN
   ,
   input  logic [$clog2(DATA_WIDTH/8)-1:0] off_i
`endif
);

   localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
   localparam int unsigned IDX_W      = $clog2(BEAT_BYTES);
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BC_W       = LEN_WIDTH + 1;

   rd_pack_state_e        state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      skip_q, skip_d;
   logic [DATA_WIDTH-1:0] pack_q, pack_d;
   logic [BC_W-1:0]       push_cnt_q, push_cnt_d;
   logic [BC_W-1:0]       pop_cnt_q, pop_cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  done_q, done_d;

   logic                  push, pop, completing;
   logic                  fifo_full, fifo_empty;
   logic [CNT_W-1:0]      fifo_cnt;
   logic [DATA_WIDTH-1:0] push_data, head;
   logic [BC_W-1:0]       last_cnt;
   logic [IDX_W-1:0]      off;

`ifdef PSRAM_RD_OFFSET_EN
   assign off = off_i;
`else
   assign off = '0;
`endif

   assign last_cnt   = {1'b0, len_q};
   assign completing = (idx_q == IDX_W'(BEAT_BYTES - 1));
   assign pop        = !fifo_empty && rready_i;
   assign push_data  = {byte_i, pack_q[DATA_WIDTH-9:0]};

   // Next-state: burst control, byte packing and beat accounting
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      skip_d     = skip_q;
      pack_d     = pack_q;
      push_cnt_d = push_cnt_q;
      pop_cnt_d  = pop_cnt_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      push       = 1'b0;

      if (pop) begin
         pop_cnt_d = pop_cnt_q + BC_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = FILL;
               len_d      = len_i;
               idx_d      = '0;
               skip_d     = off;
               push_cnt_d = '0;
               pop_cnt_d  = '0;
               ovf_d      = 1'b0;
            end
         end
         FILL: begin
            if (byte_vld_i) begin
               if (skip_q != '0) begin
                  skip_d = skip_q - IDX_W'(1);
               end else if (completing && fifo_full && !pop) begin
                  // No room for the finished beat: drop the byte, hold the index
                  ovf_d = 1'b1;
               end else begin
                  pack_d[{idx_q, 3'b000} +: 8] = byte_i;
                  idx_d = idx_q + IDX_W'(1);
                  if (completing) begin
                     push       = 1'b1;
                     push_cnt_d = push_cnt_q + BC_W'(1);
                     if (push_cnt_q == last_cnt) begin
                        state_d = DRAIN;
                     end
                  end
               end
            end
         end
         DRAIN: begin
            if (pop && (pop_cnt_q == last_cnt)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         skip_q     <= '0;
         pack_q     <= '0;
         push_cnt_q <= '0;
         pop_cnt_q  <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         skip_q     <= skip_d;
         pack_q     <= pack_d;
         push_cnt_q <= push_cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   psram_rd_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .cnt_o   (fifo_cnt)
   );

   assign byte_rdy_o = (state_q == FILL) && (fifo_cnt < CNT_W'(FIFO_DEPTH));
   assign rvalid_o   = !fifo_empty;
   assign rdata_o    = head;
   assign rlast_o    = rvalid_o && (pop_cnt_q == last_cnt);
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_psram_rd_packer.sv
// Bench for psram_rd_packer: queue-based beat model checked every cycle plus directed literals.
module tb_psram_rd_packer;

   localparam int BB    = 8;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, start, byte_vld, rready;
   logic [7:0]  len, byte_in;
   logic [2:0]  off;
   logic        byte_rdy, rvalid, rlast, busy, done, ovf;
   logic [63:0] rdata;

   always #5 clk = ~clk;

   psram_rd_packer #(.DATA_WIDTH(64), .FIFO_DEPTH(4), .LEN_WIDTH(8)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .len_i      (len),
      .byte_vld_i (byte_vld),
      .byte_i     (byte_in),
      .byte_rdy_o (byte_rdy),
      .rvalid_o   (rvalid),
      .rdata_o    (rdata),
      .rlast_o    (rlast),
      .rready_i   (rready),
      .busy_o     (busy),
      .done_o     (done),
      .ovf_o      (ovf)
`ifdef PSRAM_RD_OFFSET_EN
      ,
      .off_i      (off)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;
   int hs_cnt = 0, rlast_cnt = 0, rlast_at = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 accepting bytes, 2 waiting for the last beat to leave
   int          m_phase = 0, m_len = 0, m_pushed = 0, m_popped = 0, m_skip = 0;
   bit          m_ovf = 0, m_done = 0;
   logic [7:0]  m_bytes[$];
   logic [63:0] m_q[$];

   always @(posedge clk) begin : model_upd
      bit          pop, do_push;
      logic [63:0] beat;
      if (rst) begin
         m_phase = 0; m_len = 0; m_pushed = 0; m_popped = 0; m_skip = 0;
         m_ovf = 0; m_done = 0; m_bytes.delete(); m_q.delete();
      end else begin
         pop = (m_q.size() > 0) && rready;
         do_push = 0;
         beat = '0;
         m_done = 0;
         if (m_phase == 0) begin
            if (start) begin
               m_phase = 1; m_len = int'(len); m_pushed = 0; m_popped = 0;
               m_ovf = 0; m_bytes.delete();
`ifdef PSRAM_RD_OFFSET_EN
               m_skip = int'(off);
`else
               m_skip = 0;
`endif
            end
         end else if (m_phase == 1 && byte_vld) begin
            if (m_skip > 0) begin
               m_skip--;
            end else if (m_bytes.size() == BB - 1) begin
               if (m_q.size() < DEPTH || pop) begin
                  m_bytes.push_back(byte_in);
                  for (int i = 0; i < BB; i++) beat |= 64'(m_bytes[i]) << (8 * i);
                  m_bytes.delete();
                  do_push = 1;
               end else begin
                  m_ovf = 1;
               end
            end else begin
               m_bytes.push_back(byte_in);
            end
         end
         if (pop) begin
            void'(m_q.pop_front());
            m_popped++;
            if (m_phase == 2 && m_popped == m_len + 1) begin
               m_phase = 0;
               m_done = 1;
            end
         end
         if (do_push) begin
            m_q.push_back(beat);
            m_pushed++;
            if (m_pushed == m_len + 1) m_phase = 2;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("byte_rdy", byte_rdy, (m_phase == 1) && (m_q.size() < DEPTH));
         check("rvalid", rvalid, m_q.size() > 0);
         if (m_q.size() > 0) check("rdata", rdata, m_q[0]);
         check("rlast", rlast, (m_q.size() > 0) && (m_popped == m_len));
         check("busy", busy, m_phase != 0);
         check("done", done, m_done);
         check("ovf", ovf, m_ovf);
         if (rvalid && rready) begin
            hs_cnt++;
            if (rlast) begin
               rlast_cnt++;
               rlast_at = hs_cnt;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      byte_vld = 1'b1;
      byte_in  = b;
      tick();
      byte_vld = 1'b0;
   endtask

   task automatic begin_burst(input int l, input int o);
      start = 1'b1;
      len   = 8'(l);
      off   = 3'(o);
      tick();
      start = 1'b0;
      off   = 3'd0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check("wait_idle_timeout", busy, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_byte_rdy"}, byte_rdy, 0);
      check({tag, "_rvalid"}, rvalid, 0);
      check({tag, "_rdata"}, rdata, 0);
      check({tag, "_rlast"}, rlast, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ovf"}, ovf, 0);
   endtask

   logic [63:0] t2_beats [4];

   initial begin
      rst = 1'b1; start = 1'b0; byte_vld = 1'b0; rready = 1'b0;
      len = '0; byte_in = '0; off = '0;
      t2_beats[0] = 64'h0706050403020100;
      t2_beats[1] = 64'h0F0E0D0C0B0A0908;
      t2_beats[2] = 64'h1716151413121110;
      t2_beats[3] = 64'h1F1E1D1C1B1A1918;
      tick();
      tick();
      rst = 1'b0;
      cmp_en = 1'b1;
      check_all_zero("reset");

      // Single-beat burst
      begin_burst(0, 0);
      for (int i = 1; i <= 8; i++) send(8'(i * 17));
      check("t1_rdata", rdata, 64'h8877665544332211);
      check("t1_rvalid", rvalid, 1);
      check("t1_rlast", rlast, 1);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check("t1_done", done, 1);
      check("t1_busy", busy, 0);
      tick();
      check("t1_done_pulse", done, 0);

      // Four beats into a stalled FIFO, then ordered drain
      begin_burst(3, 0);
      for (int i = 0; i < 32; i++) send(8'(i));
      check("t2_byte_rdy", byte_rdy, 0);
      for (int k = 0; k < 4; k++) begin
         check("t2_rdata", rdata, t2_beats[k]);
         check("t2_rlast", rlast, (k == 3) ? 1 : 0);
         rready = 1'b1;
         tick();
         rready = 1'b0;
      end
      check("t2_done", done, 1);

      // Overflow on a completing byte with the FIFO full
      begin_burst(7, 0);
      for (int i = 0; i < 32; i++) send(8'(i));
      check("t3_byte_rdy_full", byte_rdy, 0);
      for (int i = 0; i < 7; i++) send(8'(8'hE0 + i));
      send(8'hEE);
      check("t3_ovf", ovf, 1);
      check("t3_head_kept", rdata, 64'h0706050403020100);
      rready = 1'b1;
      send(8'hEE);
      for (int i = 0; i < 24; i++) send(8'(8'h40 + i));
      wait_idle(50);
      rready = 1'b0;
      // Same corner with a pop coinciding with the completing byte
      begin_burst(4, 0);
      check("t3b_ovf_cleared", ovf, 0);
      for (int i = 0; i < 32; i++) send(8'(i));
      for (int i = 0; i < 7; i++) send(8'(8'hE0 + i));
      rready = 1'b1;
      send(8'hEE);
      check("t3b_ovf", ovf, 0);
      wait_idle(50);
      rready = 1'b0;

      // 256-beat stream with 50% rready
      hs_cnt = 0; rlast_cnt = 0; rlast_at = 0;
      begin_burst(255, 0);
      for (int i = 0; i < 2048; i++) begin
         rready = i[0];
         send(8'(i));
      end
      rready = 1'b1;
      wait_idle(100);
      rready = 1'b0;
      check("t4_beats", 64'(hs_cnt), 256);
      check("t4_rlast_cnt", 64'(rlast_cnt), 1);
      check("t4_rlast_at", 64'(rlast_at), 256);
      check("t4_ovf", ovf, 0);

      // Reset in the middle of a burst
      begin_burst(1, 0);
      for (int i = 0; i < 13; i++) send(8'(8'h30 + i));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("t5_rst");
      begin_burst(0, 0);
      for (int i = 0; i < 8; i++) send(8'(8'hA0 + i));
      check("t5_rdata", rdata, 64'hA7A6A5A4A3A2A1A0);
      check("t5_rlast", rlast, 1);
      rready = 1'b1;
      wait_idle(10);
      rready = 1'b0;

`ifdef PSRAM_RD_OFFSET_EN
      // Unaligned start: three leading bytes skipped
      begin_burst(0, 3);
      for (int i = 0; i <= 10; i++) send(8'(i));
      check("t6_rdata", rdata, 64'h0A09080706050403);
      check("t6_rlast", rlast, 1);
      rready = 1'b1;
      wait_idle(10);
      rready = 1'b0;
`endif

      tick();
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
